// File: rtl/mouse_cell_ctl.sv
// ---------------------------------------------------------------------------
// mouse_cell_ctl
//
// Turns a mouse click on the game board into a (column, row, action) command
// for the game logic. A button press latches the pointer position relative to
// the board origin. The press is rejected if it lies off the board. Otherwise
// the cell indices come from a repeated-subtraction divider, so no hardware
// divider is needed. The result is then offered on a valid/ready handshake.
//
// Optional feature:
//   DEBOUNCE_EN - when defined, each button level has to hold for
//                 DEBOUNCE_CYCLES consecutive samples before it is believed.
//                 When undefined, the raw levels feed the edge detector.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   asynchronous active-low reset
//   x_pos      in   [11:0] synchronized mouse x position (pixels)
//   y_pos      in   [11:0] synchronized mouse y position (pixels)
//   left       in   left button level (reveal)
//   right      in   right button level (flag toggle)
//   cmd_valid  out  command available
//   cmd_ready  in   game logic accepts the command
//   cmd_col    out  [4:0] target column
//   cmd_row    out  [4:0] target row
//   cmd_flag   out  1 = flag toggle, 0 = reveal
//   busy       out  controller is working on a click
// ---------------------------------------------------------------------------
module mouse_cell_ctl #(
    parameter int BOARD_X0        = 256,
    parameter int BOARD_Y0        = 128,
    parameter int CELL_SIZE       = 32,
    parameter int GRID_SIZE       = 16,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic        left,
    input  logic        right,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [4:0]  cmd_col,
    output logic [4:0]  cmd_row,
    output logic        cmd_flag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        ISSUE
    } state_t;

    localparam logic [12:0] CELL  = 13'(CELL_SIZE);
    localparam logic [13:0] LIMIT = 14'(GRID_SIZE * CELL_SIZE);
    localparam logic [12:0] X0    = 13'(BOARD_X0);
    localparam logic [12:0] Y0    = 13'(BOARD_Y0);

    logic leftLvl;
    logic rightLvl;

`ifdef DEBOUNCE_EN
    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        leftStable_q;
    logic        rightStable_q;
    logic [19:0] leftCnt_q;
    logic [19:0] rightCnt_q;

    // Debounce: the counter tracks how many consecutive samples have differed
    // from the accepted level. When the count reaches DEBOUNCE_CYCLES, the new
    // level is taken. Any sample that agrees with the accepted level restarts
    // the count, so short glitches never get through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leftStable_q  <= 1'b0;
            rightStable_q <= 1'b0;
            leftCnt_q     <= '0;
            rightCnt_q    <= '0;
        end else begin
            if (left == leftStable_q) begin
                leftCnt_q <= '0;
            end else if (leftCnt_q == DB_LAST) begin
                leftStable_q <= left;
                leftCnt_q    <= '0;
            end else begin
                leftCnt_q <= leftCnt_q + 20'd1;
            end

            if (right == rightStable_q) begin
                rightCnt_q <= '0;
            end else if (rightCnt_q == DB_LAST) begin
                rightStable_q <= right;
                rightCnt_q    <= '0;
            end else begin
                rightCnt_q <= rightCnt_q + 20'd1;
            end
        end
    end

    assign leftLvl  = leftStable_q;
    assign rightLvl = rightStable_q;
`else
    assign leftLvl  = left;
    assign rightLvl = right;

    // Without debouncing, DEBOUNCE_CYCLES only matters as a range sanity
    // check, so an out-of-range value is still visible in the elaborated tree.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce_cycles
    end
`endif

    logic leftPrev_q;
    logic rightPrev_q;

    // Previous-cycle button levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leftPrev_q  <= 1'b0;
            rightPrev_q <= 1'b0;
        end else begin
            leftPrev_q  <= leftLvl;
            rightPrev_q <= rightLvl;
        end
    end

    logic leftPress;
    logic rightPress;

    assign leftPress  = leftLvl  & ~leftPrev_q;
    assign rightPress = rightLvl & ~rightPrev_q;

    state_t      state_q;
    logic [12:0] relX_q;
    logic [12:0] relY_q;
    logic [4:0]  col_q;
    logic [4:0]  row_q;
    logic        cmdValid_q;
    logic        cmdFlag_q;

    logic        xMore;
    logic        yMore;
    logic [12:0] relX_d;
    logic [12:0] relY_d;
    logic        divDone;
    logic        offBoard;

    // One divider step. Leaving DIV is decided on the values after this step,
    // which saves a cycle per click. Both axes step together, so the worst
    // case is still bounded by the larger of the two quotients.
    assign xMore   = (relX_q >= CELL);
    assign yMore   = (relY_q >= CELL);
    assign relX_d  = xMore ? (relX_q - CELL) : relX_q;
    assign relY_d  = yMore ? (relY_q - CELL) : relY_q;
    assign divDone = (relX_d < CELL) && (relY_d < CELL);

    // Bit 12 is the sign of the relative position. A negative value means
    // the click landed left of or above the board.
    assign offBoard = relX_q[12] || relY_q[12] ||
                      ({1'b0, relX_q} >= LIMIT) || ({1'b0, relY_q} >= LIMIT);

    // Main controller. When both buttons rise together, left wins. Any press
    // outside IDLE is simply not looked at, so it is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            relX_q     <= '0;
            relY_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cmdValid_q <= 1'b0;
            cmdFlag_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmdValid_q <= 1'b0;
                    if (leftPress || rightPress) begin
                        relX_q    <= {1'b0, x_pos} - X0;
                        relY_q    <= {1'b0, y_pos} - Y0;
                        cmdFlag_q <= rightPress & ~leftPress;
                        col_q     <= '0;
                        row_q     <= '0;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= offBoard ? IDLE : DIV;
                end
                DIV: begin
                    relX_q <= relX_d;
                    relY_q <= relY_d;
                    if (xMore) begin
                        col_q <= col_q + 5'd1;
                    end
                    if (yMore) begin
                        row_q <= row_q + 5'd1;
                    end
                    if (divDone) begin
                        cmdValid_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmdValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    cmdValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = cmdValid_q;
    assign cmd_col   = col_q;
    assign cmd_row   = row_q;
    assign cmd_flag  = cmdFlag_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mouse_cell_ctl.sv
// ---------------------------------------------------------------------------
// tb_mouse_cell_ctl
//
// Self-checking bench for mouse_cell_ctl at its default parameters, without
// debouncing. A table of directed clicks covers the board corners, the cell
// boundaries and the off-board edges. Random clicks follow, checked against
// a small arithmetic model of the board. Hand-written sequences cover the
// stalled handshake and an asynchronous reset during the divide.
// ---------------------------------------------------------------------------
module tb_mouse_cell_ctl;

    localparam int X0   = 256;
    localparam int Y0   = 128;
    localparam int CELL = 32;
    localparam int GRID = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xPos;
    logic [11:0] yPos;
    logic        leftBtn;
    logic        rightBtn;
    logic        cmdReady;
    logic        cmd_valid;
    logic [4:0]  cmd_col;
    logic [4:0]  cmd_row;
    logic        cmd_flag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mouse_cell_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .x_pos     (xPos),
        .y_pos     (yPos),
        .left      (leftBtn),
        .right     (rightBtn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmdReady),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_flag  (cmd_flag),
        .busy      (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit l;
        bit r;
        bit expValid;
        int expCol;
        int expRow;
        bit expFlag;
    } vec_t;

    vec_t vecs[10];

    // Counts one comparison and reports it when it is wrong.
    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives the pointer position and the button levels.
    task automatic applyStimulus(input int x, input int y, input bit l, input bit r);
        xPos     = 12'(x);
        yPos     = 12'(y);
        leftBtn  = l;
        rightBtn = r;
    endtask

    // Board model: the cell is the integer quotient of the offset from the
    // board origin, and anything outside the GRID x GRID square is ignored.
    function automatic void modelCmd(input int x, input int y, input bit l, input bit r,
                                     output bit v, output int col, output int row,
                                     output bit f);
        int rx;
        int ry;
        rx  = x - X0;
        ry  = y - Y0;
        v   = (l || r) && rx >= 0 && ry >= 0 && rx < GRID * CELL && ry < GRID * CELL;
        col = v ? rx / CELL : 0;
        row = v ? ry / CELL : 0;
        f   = r && !l;
    endfunction

    // One click with cmd_ready held high. The buttons are held for a single
    // cycle, and the bench waits a bounded time for the command.
    task automatic runCase(input string name, input int x, input int y, input bit l,
                           input bit r, input bit expV, input int expCol,
                           input int expRow, input bit expF);
        bit seen;
        int lat;
        int gotCol;
        int gotRow;
        int gotFlag;
        int busyAt2;
        seen    = 1'b0;
        lat     = 0;
        gotCol  = 0;
        gotRow  = 0;
        gotFlag = 0;
        busyAt2 = 0;
        @(negedge clk);
        applyStimulus(x, y, l, r);
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                leftBtn  = 1'b0;
                rightBtn = 1'b0;
            end
            if (k == 2) busyAt2 = busy;
            if (cmd_valid) begin
                seen    = 1'b1;
                lat     = k;
                gotCol  = cmd_col;
                gotRow  = cmd_row;
                gotFlag = cmd_flag;
            end
        end
        if (expV) begin
            checkOutput({name, "_seen"}, seen, 1);
            if (seen) begin
                checkOutput({name, "_latency_le18"}, (lat <= 18) ? 1 : 0, 1);
                checkOutput({name, "_col"}, gotCol, expCol);
                checkOutput({name, "_row"}, gotRow, expRow);
                checkOutput({name, "_flag"}, gotFlag, expF);
                @(negedge clk);
                checkOutput({name, "_one_cycle"}, cmd_valid, 0);
            end
        end else begin
            checkOutput({name, "_no_cmd"}, seen, 0);
            checkOutput({name, "_busy_clear"}, busyAt2, 0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit mv;
        bit mf;
        int mc;
        int mr;
        int x;
        int y;
        bit l;
        bit r;
        int cnt;
        bit seen;

        vecs[0] = '{300, 200, 1'b1, 1'b0, 1'b1, 1, 2, 1'b0};
        vecs[1] = '{767, 639, 1'b0, 1'b1, 1'b1, 15, 15, 1'b1};
        vecs[2] = '{768, 200, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[3] = '{255, 200, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[4] = '{288, 160, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
        vecs[5] = '{256, 128, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1};
        vecs[6] = '{287, 159, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0};
        vecs[7] = '{300, 127, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[8] = '{400, 639, 1'b0, 1'b1, 1'b1, 4, 15, 1'b1};
        vecs[9] = '{300, 640, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};

        rst      = 1'b0;
        cmdReady = 1'b1;
        applyStimulus(0, 0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_outputs",
                    int'({cmd_valid, cmd_col, cmd_row, cmd_flag, busy}), 0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            runCase($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].r,
                    vecs[i].expValid, vecs[i].expCol, vecs[i].expRow, vecs[i].expFlag);
        end

        // Random clicks around and across the board.
        for (int i = 0; i < 25; i++) begin
            x = $urandom_range(200, 830);
            y = $urandom_range(80, 700);
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            modelCmd(x, y, l, r, mv, mc, mr, mf);
            runCase($sformatf("rand%0d", i), x, y, l, r, mv, mc, mr, mf);
        end

        // Stalled handshake: the outputs hold for 10 cycles and a press made
        // during the stall is dropped.
        cmdReady = 1'b0;
        @(negedge clk);
        applyStimulus(300, 200, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) leftBtn = 1'b0;
            if (cmd_valid) seen = 1'b1;
        end
        checkOutput("stall_seen", seen, 1);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("stall_stable%0d", c),
                        int'({cmd_valid, cmd_col, cmd_row, cmd_flag}),
                        int'({1'b1, 5'd1, 5'd2, 1'b0}));
            if (c == 2) applyStimulus(700, 600, 1'b0, 1'b1);
            if (c == 3) rightBtn = 1'b0;
            @(negedge clk);
        end
        cmdReady = 1'b1;
        @(negedge clk);
        checkOutput("stall_handshake", cmd_valid, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_valid) cnt++;
        end
        checkOutput("stall_no_extra", cnt, 0);

        // Asynchronous reset while the divider is running.
        @(negedge clk);
        applyStimulus(767, 639, 1'b0, 1'b1);
        @(negedge clk);
        rightBtn = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_pre_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_outputs",
                    int'({cmd_valid, cmd_col, cmd_row, cmd_flag, busy}), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_valid) cnt++;
        end
        checkOutput("rst_no_cmd", cnt, 0);

        // Normal operation resumes after the aborted command.
        runCase("post_rst", 480, 300, 1'b1, 1'b0, 1'b1, 7, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_cell_ctl.md
MOUSE_CELL_CTL -- requirements
Module: mouse_cell_ctl

Interface
REQ-001 SHALL have parameter BOARD_X0, default 256, meaning board left edge in pixels.
REQ-002 SHALL have parameter BOARD_Y0, default 128, meaning board top edge in pixels.
REQ-003 SHALL have parameter CELL_SIZE, default 32, meaning cell edge in pixels (1..255).
REQ-004 SHALL have parameter GRID_SIZE, default 16, meaning cells per row and column (1..31).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 65000, meaning button stable time in clk cycles (1..2^20-1).
REQ-006 SHALL have port clk, input, 1, meaning single system clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port x_pos, input, 12, meaning synchronized mouse x position.
REQ-009 SHALL have port y_pos, input, 12, meaning synchronized mouse y position.
REQ-010 SHALL have port left, input, 1, meaning left button level (reveal).
REQ-011 SHALL have port right, input, 1, meaning right button level (flag).
REQ-012 SHALL have port cmd_valid, output, 1, meaning command available.
REQ-013 SHALL have port cmd_ready, input, 1, meaning game logic accepts command.
REQ-014 SHALL have port cmd_col, output, 5, meaning target column.
REQ-015 SHALL have port cmd_row, output, 5, meaning target row.
REQ-016 SHALL have port cmd_flag, output, 1, meaning 1 = flag toggle, 0 = reveal.
REQ-017 SHALL have port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-018 SHALL detect a press as a 0->1 transition of the (debounced) button level, registered against the previous-cycle level.
REQ-019 SHALL implement FSM IDLE -> CHECK -> DIV -> ISSUE -> IDLE; busy = (state != IDLE).
REQ-020 IDLE: on press, SHALL latch rel_x = x_pos - BOARD_X0, rel_y = y_pos - BOARD_Y0 (13-bit, sign retained), cmd_flag = right-only press, clear col/row counters, go CHECK.
REQ-021 On simultaneous left and right presses, left SHALL win (cmd_flag = 0); right press SHALL be discarded.
REQ-022 CHECK: if rel_x or rel_y negative, or >= GRID_SIZE*CELL_SIZE, SHALL return to IDLE with no command; else go DIV.
REQ-023 DIV: each cycle, SHALL subtract CELL_SIZE from rel_x and increment col while rel_x >= CELL_SIZE, same for rel_y/row in parallel; when both below CELL_SIZE, go ISSUE.
REQ-024 Worst-case press-to-cmd_valid latency SHALL be GRID_SIZE+2 cycles; a pixel exactly on a cell boundary SHALL belong to the higher cell.
REQ-025 ISSUE: cmd_valid = 1 with cmd_col/cmd_row/cmd_flag stable until the cycle cmd_valid && cmd_ready; then go IDLE.
REQ-026 Presses occurring while busy = 1 SHALL be dropped, not queued.
REQ-027 cmd_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-028 rst low SHALL immediately force state IDLE, cmd_valid 0, cmd_col 0, cmd_row 0, cmd_flag 0, busy 0, debounce counters and previous-level registers 0.
REQ-029 Reset asserted mid-DIV or mid-ISSUE SHALL abort the command with no handshake completion.

Configuration
REQ-030 With DEBOUNCE_EN defined, each button level SHALL be accepted only after DEBOUNCE_CYCLES consecutive identical samples (20-bit counter per button).
REQ-031 Without DEBOUNCE_EN, raw left/right SHALL feed edge detection directly; no debounce counters synthesized.

Verification
REQ-032 Defaults, no DEBOUNCE_EN, left press at (300,200), cmd_ready=1 -> cmd_valid with col 1, row 2, flag 0, within 18 cycles, one cycle high.
REQ-033 Right press at (767,639) -> col 15, row 15, flag 1; press at (768,200) or (255,200) -> no cmd_valid, busy back to 0 within 2 cycles.
REQ-034 cmd_ready held 0 for 10 cycles in ISSUE -> cmd_valid and outputs stable 10 cycles; extra presses ignored; single command after ready.
REQ-035 Left and right rise same cycle at (288,160) -> one command col 1, row 1, flag 0.
REQ-036 DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle glitch -> no command; 6-cycle press -> one command; rst pulsed low in DIV -> all outputs 0 asynchronously, no command.
